// File: rtl/cache_wb_pkg.sv
// Shared types and default widths for the cache posted-write buffer.
// wb_entry_t is the default-width FIFO entry layout.
package cache_wb_pkg;

    localparam int unsigned WB_DEPTH      = 4;
    localparam int unsigned WB_ADDR_WIDTH = 32;
    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_BE_WIDTH   = WB_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_OUT = 2'd1,
        RD_OUT = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic [WB_BE_WIDTH-1:0]   be;
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Power-of-two deep FIFO of posted writes; the head is always visible on data_o.
// Full is judged on the current count, so a push is refused when full even if a pop happens.
module wb_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic [31:0]
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  entry_t                   data_i,
    input  logic                     pop_i,
    output entry_t                   data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned         PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]      CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]      CNT_FULL = (PTR_W + 1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CNT_FULL);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been pushed.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cache_write_buffer.sv
// Posted-write buffer between the data cache port and the TCDM path to L2.
// Writes are acknowledged at once and drained in order; reads pass through only when the buffer is idle.
module cache_write_buffer
    import cache_wb_pkg::*;
#(
    parameter int unsigned DEPTH      = WB_DEPTH,
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
    parameter int unsigned BE_WIDTH   = WB_BE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  up_req_i,
    output logic                  up_gnt_o,
    input  logic                  up_we_i,
    input  logic [BE_WIDTH-1:0]   up_be_i,
    input  logic [ADDR_WIDTH-1:0] up_addr_i,
    input  logic [DATA_WIDTH-1:0] up_wdata_i,
    output logic                  up_rvalid_o,
    output logic [DATA_WIDTH-1:0] up_rdata_o,
    output logic                  up_err_o,
    output logic                  dn_req_o,
    input  logic                  dn_gnt_i,
    output logic                  dn_we_o,
    output logic [BE_WIDTH-1:0]   dn_be_o,
    output logic [ADDR_WIDTH-1:0] dn_addr_o,
    output logic [DATA_WIDTH-1:0] dn_wdata_o,
    input  logic                  dn_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dn_rdata_i,
    input  logic                  dn_err_i,
    output logic                  empty_o,
    output logic                  wr_err_o
);

    // Same layout as wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [BE_WIDTH-1:0]   be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } entry_t;

    wb_state_e state_q, state_d;
    logic      wr_rsp_q, wr_rsp_d;
    logic      wr_err_q, wr_err_d;

    entry_t                 push_data;
    entry_t                 head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic                   wr_accept;
    logic                   fifo_pop;
    logic                   rd_eligible;
    logic                   rd_issue;
    logic                   rd_rsp;

    assign push_data = '{be: up_be_i, addr: up_addr_i, wdata: up_wdata_i};

    wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (wr_accept),
        .data_i  (push_data),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign wr_accept   = up_req_i & up_we_i & ~fifo_full;
    assign rd_eligible = fifo_empty & (state_q == IDLE) & ~wr_rsp_q;
    assign rd_issue    = rd_eligible & up_req_i & ~up_we_i;
    assign fifo_pop    = (state_q == IDLE) & ~fifo_empty & dn_gnt_i;
    assign rd_rsp      = (state_q == RD_OUT) & dn_rvalid_i;

    assign up_gnt_o    = wr_accept | (rd_issue & dn_gnt_i);
    assign up_rvalid_o = wr_rsp_q | rd_rsp;
    assign up_rdata_o  = rd_rsp ? dn_rdata_i : '0;
    assign up_err_o    = rd_rsp & dn_err_i;

    assign empty_o  = fifo_empty & (state_q == IDLE);
    assign wr_err_o = wr_err_q;

    // Queued writes win over a pending read; requests only leave from IDLE.
    always_comb begin
        dn_req_o   = 1'b0;
        dn_we_o    = 1'b0;
        dn_be_o    = '0;
        dn_addr_o  = '0;
        dn_wdata_o = '0;
        if (state_q == IDLE) begin
            if (!fifo_empty) begin
                dn_req_o   = 1'b1;
                dn_we_o    = 1'b1;
                dn_be_o    = head.be;
                dn_addr_o  = head.addr;
                dn_wdata_o = head.wdata;
            end else if (rd_issue) begin
                dn_req_o  = 1'b1;
                dn_be_o   = up_be_i;
                dn_addr_o = up_addr_i;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_rsp_d = wr_accept;
        wr_err_d = wr_err_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (dn_gnt_i) begin
                        state_d = WR_OUT;
                    end
                end else if (rd_issue && dn_gnt_i) begin
                    state_d = RD_OUT;
                end
            end
            WR_OUT: begin
                if (dn_rvalid_i) begin
                    state_d = IDLE;
                    if (dn_err_i) begin
                        wr_err_d = 1'b1;
                    end
                end
            end
            RD_OUT: begin
                if (dn_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            wr_rsp_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_rsp_q <= wr_rsp_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Posted and read responses can never collide on the upstream channel.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(wr_rsp_q && rd_rsp));
    assert property (@(posedge clk_i) disable iff (!rst_ni) fifo_empty == (fifo_cnt == '0));

endmodule

// File: doc/cache_write_buffer.md
Name: cache_write_buffer

Overview:
- Posted-write buffer between the data cache memory port (OBI-style request/grant/rvalid) and the TCDM slave path toward L2.
- Acknowledges cache writes immediately and drains them to memory in order from a small FIFO.
- Reads wait until the buffer is empty and idle, then pass through with one transaction outstanding downstream.
- Hides L2 write latency from cache write-backs and write-throughs.

Parameters:
- DEPTH, 4: write FIFO entries; power of two, ≥2.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width.
- BE_WIDTH, 4: byte-enable width, DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- up_req_i  in  1  cache request.
- up_gnt_o  out  1  grant to cache.
- up_we_i  in  1  1 = write.
- up_be_i  in  BE_WIDTH  byte enables.
- up_addr_i  in  ADDR_WIDTH  address.
- up_wdata_i  in  DATA_WIDTH  write data.
- up_rvalid_o  out  1  response valid.
- up_rdata_o  out  DATA_WIDTH  read data.
- up_err_o  out  1  response error.
- dn_req_o  out  1  memory request.
- dn_gnt_i  in  1  memory grant.
- dn_we_o  out  1  1 = write.
- dn_be_o  out  BE_WIDTH  byte enables.
- dn_addr_o  out  ADDR_WIDTH  address.
- dn_wdata_o  out  DATA_WIDTH  write data.
- dn_rvalid_i  in  1  memory response valid.
- dn_rdata_i  in  DATA_WIDTH  memory read data.
- dn_err_i  in  1  memory error.
- empty_o  out  1  FIFO empty and state IDLE.
- wr_err_o  out  1  sticky: a drained write returned an error.

Behaviour:
- Reset:
  - FIFO pointers and count are 0; state is IDLE.
  - All outputs are 0 except empty_o = 1.
- Upstream write:
  - up_gnt_o = up_req_i & up_we_i & ~full, combinational.
  - On grant, {be, addr, wdata} is pushed into the FIFO.
  - up_rvalid_o = 1 exactly one cycle later, with up_err_o = 0 and up_rdata_o = 0.
- Upstream read:
  - Eligible only when the FIFO is empty, state is IDLE, and no posted write response is due this cycle.
  - When eligible: dn_req_o = up_req_i, dn_we_o = 0, and addr/be come from upstream.
  - up_gnt_o = dn_gnt_i, combinational pass-through.
  - Otherwise up_gnt_o = 0 and the cache holds its request stable (OBI rule).
- Downstream FSM, at most one transaction outstanding:
  - IDLE: if the FIFO is non-empty, drive dn_req_o = 1 with the FIFO head and dn_we_o = 1. On dn_gnt_i, pop the head and go to WR_OUT. Else if a read is eligible and up_req_i is high, issue it; on dn_gnt_i go to RD_OUT.
  - Writes have priority over reads.
  - The FIFO head is held stable while dn_req_o is high and ungranted.
  - WR_OUT: on dn_rvalid_i go to IDLE. If dn_err_i is also high, set wr_err_o (sticky until reset). Nothing is forwarded upstream.
  - RD_OUT: on dn_rvalid_i, drive up_rvalid_o, up_rdata_o = dn_rdata_i and up_err_o = dn_err_i combinationally, then go to IDLE.
  - dn_req_o is asserted only in IDLE, so the minimum downstream spacing is grant, response, then one IDLE cycle.
- Push and pop in the same cycle: count is unchanged. Full is evaluated before the pop, so a push on a full FIFO is refused even if a pop occurs.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Ordering: a read is never issued ahead of an earlier-accepted write. The posted write rvalid (at gnt+1) always precedes any read rvalid (at gnt+2 or later), so up_rvalid_o is never doubly driven.
- dn_rvalid_i outside WR_OUT/RD_OUT is ignored.
- Asynchronous reset mid-transaction: FIFO contents and outstanding transactions are discarded. The environment resets memory and cache together.

Decomposition:
- Package cache_wb_pkg holds:
  - the wb_state_e typedef (IDLE, WR_OUT, RD_OUT);
  - the wb_entry_t struct {be, addr, wdata};
  - default width constants.
- Sub-module wb_fifo (parametric DEPTH, entry type) provides push/pop/full/empty/count.
- The FSM and muxing live in the top module.

Test Plan:
- Single write: addr 0x1C000010, data 0xDEADBEEF, be 0xF, dn_gnt_i immediate.
  - up_gnt_o in the same cycle, up_rvalid_o at +1.
  - dn write with identical fields at +1, WR_OUT, and empty_o back to 1 after dn_rvalid_i.
- Five back-to-back writes with dn_gnt_i = 0: four granted, the fifth stalls with up_gnt_o = 0. Raising dn_gnt_i drains addresses in order 0x0, 0x4, 0x8, 0xC, 0x10.
- Write 0x100 = 0x12345678, then an immediate read of 0x100: read gnt is withheld until the write's dn_rvalid_i. The read is then issued with dn_we_o = 0, and up_rdata_o = 0x12345678 from the model.
- Read with a 3-cycle dn_gnt_i delay and a 2-cycle dn_rvalid_i delay, FIFO empty: up_gnt_o mirrors dn_gnt_i, and up_rvalid_o/up_rdata_o mirror the response.
- Drained write answered with dn_err_i = 1: wr_err_o goes to 1 and stays 1 across later transactions. up_err_o for that write was 0.
- Assert rst_ni low with 3 entries queued while in WR_OUT: empty_o = 1, dn_req_o = 0 and wr_err_o = 0 immediately. No further dn requests after release.
